// File: rtl/rv_pkg.sv
// Shared RV32 writeback definitions: data width, load funct3 encodings and
// the load-return record carried through the writeback FIFO.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Raw load return; extension happens after the FIFO, never before.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
    logic [1:0]      byte_off;
  } wb_load_t;

endpackage

// File: rtl/load_extend.sv
// Load byte/halfword extraction and sign/zero extension (combinational).
// Undefined funct3 encodings are passed through as a full word.
module load_extend
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] ext
);

  logic [XLEN-1:0] shifted;

  // Align the addressed byte to bit 0, then extend according to load type.
  always_comb begin
    shifted = data >> {byte_off, 3'b000};
    case (funct3)
      F3_LB:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      // At off=3 only one byte remains after the shift; extend from its bit 7.
      F3_LH:  ext = (byte_off == 2'd3) ? {{(XLEN-8){shifted[7]}}, shifted[7:0]}
                                       : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU: ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: sole driver of the register file write port. Merges ALU
// results and load returns (ALU has priority), queueing losing loads in a FIFO.
// Optional macro WB_X0_FILTER_EN suppresses all writes targeting x0.
// XLEN must match rv_pkg::XLEN since FIFO entries use the package record.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 2,
  parameter int unsigned XLEN           = rv_pkg::XLEN
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              alu_valid,
  input  logic [4:0]                        alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              lsu_valid,
  output logic                              lsu_ready,
  input  logic [4:0]                        lsu_rd,
  input  logic [XLEN-1:0]                   lsu_data,
  input  logic [2:0]                        lsu_funct3,
  input  logic [1:0]                        lsu_byte_off,
  output logic                              we3,
  output logic [4:0]                        a3,
  output logic [XLEN-1:0]                   wd3,
  output logic [$clog2(LSU_FIFO_DEPTH):0]   wb_pending
);

  localparam int unsigned PW = $clog2(LSU_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_load_t        mem_q [LSU_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            we3_q, load_out_q;
  logic [4:0]      a3_q;
  logic [XLEN-1:0] wd3_q;

  wb_load_t        incoming, sel_load;
  logic            fifo_empty, accept, alu_x0, lsu_x0;
  logic            alu_win, fifo_win, bypass, push, pop;
  logic [XLEN-1:0] load_ext;

  assign fifo_empty = (count_q == '0);
  // Registered count only, so ready never depends on a same-cycle pop.
  assign lsu_ready  = (count_q != CW'(LSU_FIFO_DEPTH));
  assign accept     = lsu_valid && lsu_ready;

`ifdef WB_X0_FILTER_EN
  assign alu_x0 = (alu_rd == 5'd0);
  assign lsu_x0 = (lsu_rd == 5'd0);
`else
  assign alu_x0 = 1'b0;
  assign lsu_x0 = 1'b0;
`endif

  // Source selection and FIFO push/pop decisions.
  always_comb begin
    incoming.rd       = lsu_rd;
    incoming.data     = lsu_data;
    incoming.funct3   = lsu_funct3;
    incoming.byte_off = lsu_byte_off;
    alu_win  = alu_valid && !alu_x0;
    fifo_win = !alu_win && !fifo_empty;
    bypass   = !alu_win && fifo_empty && accept && !lsu_x0;
    pop      = fifo_win;
    push     = accept && !lsu_x0 && !bypass;
    sel_load = fifo_win ? mem_q[rd_ptr_q] : incoming;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  load_extend u_load_extend (
    .data     (sel_load.data),
    .funct3   (sel_load.funct3),
    .byte_off (sel_load.byte_off),
    .ext      (load_ext)
  );

  // FIFO storage holds raw entries; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= incoming;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we3_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      load_out_q <= 1'b0;
    end else if (alu_win) begin
      we3_q      <= 1'b1;
      a3_q       <= alu_rd;
      wd3_q      <= alu_data;
      load_out_q <= 1'b0;
    end else if (fifo_win || bypass) begin
      we3_q      <= 1'b1;
      a3_q       <= sel_load.rd;
      wd3_q      <= load_ext;
      load_out_q <= 1'b1;
    end else begin
      we3_q      <= 1'b0;
      load_out_q <= 1'b0;
    end
  end

  assign we3        = we3_q;
  assign a3         = a3_q;
  assign wd3        = wd3_q;
  assign wb_pending = count_q + CW'(load_out_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected {a3,wd3} writes,
// a negedge monitor pops and compares every we3 pulse.
module tb_wb_arbiter;
  import rv_pkg::*;

  logic        clk, resetn;
  logic        alu_valid, lsu_valid, lsu_ready, we3;
  logic [4:0]  alu_rd, lsu_rd, a3;
  logic [31:0] alu_data, lsu_data, wd3;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_byte_off;
  logic [1:0]  wb_pending;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];
  vec_t bp_ld[3];

  wb_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_funct3   (lsu_funct3),
    .lsu_byte_off (lsu_byte_off),
    .we3          (we3),
    .a3           (a3),
    .wd3          (wd3),
    .wb_pending   (wb_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; lsu_funct3 = '0; lsu_byte_off = '0;
  endtask

  task automatic drive_load(input vec_t v);
    lsu_valid = 1'b1; lsu_rd = v.rd; lsu_data = v.data;
    lsu_funct3 = v.f3; lsu_byte_off = v.off;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      step();
      g++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && we3) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got a3=%0d wd3=%h required no write", a3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        if ({a3, wd3} !== mon_e) begin
          n_fail++;
          $display("FAIL write_data: got a3=%0d wd3=%h required a3=%0d wd3=%h",
                   a3, wd3, mon_e[36:32], mon_e[31:0]);
        end
      end
`ifdef WB_X0_FILTER_EN
      check("x0_never_written", {31'd0, a3 == 5'd0}, 32'd0);
`endif
    end
  end

  initial begin
    vec_t tmp;
    int nacc;
    int g;
    logic will_acc;

    vecs[0] = '{rd: 5'd5,  data: 32'h8070_6050, f3: F3_LB,  off: 2'd1, exp: 32'h0000_0060};
    vecs[1] = '{rd: 5'd6,  data: 32'h8001_1234, f3: F3_LH,  off: 2'd2, exp: 32'hFFFF_8001};
    vecs[2] = '{rd: 5'd7,  data: 32'h8001_1234, f3: F3_LHU, off: 2'd2, exp: 32'h0000_8001};
    vecs[3] = '{rd: 5'd8,  data: 32'h80A1_B2C3, f3: F3_LH,  off: 2'd3, exp: 32'hFFFF_FF80};
    vecs[4] = '{rd: 5'd9,  data: 32'h80A1_B2C3, f3: F3_LHU, off: 2'd3, exp: 32'h0000_0080};
    vecs[5] = '{rd: 5'd10, data: 32'h1234_5678, f3: F3_LW,  off: 2'd3, exp: 32'h1234_5678};
    vecs[6] = '{rd: 5'd11, data: 32'hCAFE_F00D, f3: 3'b011, off: 2'd1, exp: 32'hCAFE_F00D};
    vecs[7] = '{rd: 5'd12, data: 32'h0000_F000, f3: F3_LB,  off: 2'd1, exp: 32'hFFFF_FFF0};
    vecs[8] = '{rd: 5'd13, data: 32'h0000_F000, f3: F3_LBU, off: 2'd1, exp: 32'h0000_00F0};
    bp_ld[0] = '{rd: 5'd20, data: 32'h1111_0000, f3: F3_LW, off: 2'd0, exp: 32'h1111_0000};
    bp_ld[1] = '{rd: 5'd21, data: 32'h2222_0000, f3: F3_LW, off: 2'd0, exp: 32'h2222_0000};
    bp_ld[2] = '{rd: 5'd22, data: 32'h3333_0000, f3: F3_LW, off: 2'd0, exp: 32'h3333_0000};

    // Reset values.
    idle();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("reset_we3", {31'd0, we3}, 32'd0);
    check("reset_a3", {27'd0, a3}, 32'd0);
    check("reset_wd3", wd3, 32'd0);
    check("reset_pending", {30'd0, wb_pending}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    check("reset_ready", {31'd0, lsu_ready}, 32'd1);

    // Bypass loads back to back, covering every extension case.
    foreach (vecs[i]) begin
      drive_load(vecs[i]);
      expect_wr(vecs[i].rd, vecs[i].exp);
      step();
    end
    idle();
    check("bypass_pending_1", {30'd0, wb_pending}, 32'd1);
    step();
    check("bypass_pending_0", {30'd0, wb_pending}, 32'd0);

    // ALU and load collide: ALU first, load one cycle later.
    drive_alu(5'd3, 32'd7);
    tmp = '{rd: 5'd4, data: 32'hDEAD_BEEF, f3: F3_LW, off: 2'd0, exp: 32'hDEAD_BEEF};
    drive_load(tmp);
    expect_wr(5'd3, 32'd7);
    expect_wr(5'd4, 32'hDEAD_BEEF);
    step();
    idle();
    check("coll_pending_c1", {30'd0, wb_pending}, 32'd1);
    step();
    check("coll_pending_c2", {30'd0, wb_pending}, 32'd1);
    step();
    check("coll_pending_c3", {30'd0, wb_pending}, 32'd0);

    // Backpressure: ALU holds the port for 4 cycles while 3 loads are offered.
    for (int i = 0; i < 4; i++) expect_wr(5'(16 + i), 32'h100 + i);
    foreach (bp_ld[i]) expect_wr(bp_ld[i].rd, bp_ld[i].exp);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      drive_alu(5'(16 + i), 32'h100 + i);
      if (nacc < 3) drive_load(bp_ld[nacc]);
      else lsu_valid = 1'b0;
      if (i == 2) begin
        check("bp_ready_drop", {31'd0, lsu_ready}, 32'd0);
        check("bp_accepts_before_drop", nacc, 2);
        check("bp_pending_full", {30'd0, wb_pending}, 32'd2);
      end
      will_acc = lsu_valid && lsu_ready;
      step();
      if (will_acc) nacc++;
    end
    alu_valid = 1'b0;
    g = 0;
    while (nacc < 3 && g < 20) begin
      drive_load(bp_ld[nacc]);
      will_acc = lsu_ready;
      step();
      if (will_acc) nacc++;
      g++;
    end
    idle();
    check("bp_all_accepted", nacc, 3);
    drain("bp_drain");
    step();

    // Reset while a write is on the port and one load is queued.
    drive_alu(5'd24, 32'd1);
    tmp = '{rd: 5'd25, data: 32'h77, f3: F3_LW, off: 2'd0, exp: 32'h77};
    drive_load(tmp);
    step();
    idle();
    check("mid_we3_before", {31'd0, we3}, 32'd1);
    check("mid_pending_before", {30'd0, wb_pending}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_we3_async", {31'd0, we3}, 32'd0);
    check("mid_pending_async", {30'd0, wb_pending}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    check("mid_ready_after", {31'd0, lsu_ready}, 32'd1);
    step();
    step();
    step();
    check("mid_no_write", {31'd0, we3}, 32'd0);
    check("mid_pending_after", {30'd0, wb_pending}, 32'd0);

    // ALU write to x0 alongside a queued load.
    expect_wr(5'd26, 32'd5);
`ifndef WB_X0_FILTER_EN
    expect_wr(5'd0, 32'h99);
`endif
    expect_wr(5'd27, 32'h55);
    drive_alu(5'd26, 32'd5);
    tmp = '{rd: 5'd27, data: 32'h55, f3: F3_LW, off: 2'd0, exp: 32'h55};
    drive_load(tmp);
    step();
    lsu_valid = 1'b0;
    drive_alu(5'd0, 32'h99);
    step();
    idle();
    drain("x0_alu_drain");

    // Load to x0.
    tmp = '{rd: 5'd0, data: 32'hAA, f3: F3_LW, off: 2'd0, exp: 32'hAA};
    drive_load(tmp);
`ifndef WB_X0_FILTER_EN
    expect_wr(5'd0, 32'hAA);
`endif
    check("x0_load_ready", {31'd0, lsu_ready}, 32'd1);
    step();
    idle();
`ifdef WB_X0_FILTER_EN
    check("x0_load_pending", {30'd0, wb_pending}, 32'd0);
`else
    check("x0_load_pending", {30'd0, wb_pending}, 32'd1);
`endif
    drain("final_drain");
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
